// File: rtl/rx_gate_pkg.sv
// Shared types and sizing helpers for the multi-channel RX gate.
package rx_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } gate_state_e;

  function automatic int words_per_beat(input int data_width);
    return data_width / 32;
  endfunction

  // $clog2(timeout+1), floored at 1 bit so a disabled timeout still sizes legally.
  function automatic int tcnt_width(input int ack_timeout);
    return (ack_timeout < 1) ? 1 : $clog2(ack_timeout + 1);
  endfunction

endpackage

// File: rtl/rx_channel_gate_fsm.sv
// Single-channel RX gate: offer/ack handshake, ack timeout, FIFO gating and word accounting.
module rx_channel_gate_fsm
  import rx_gate_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rx_last,
  input  logic [31:0] rx_len,
  input  logic [30:0] rx_off,
  input  logic        rd_empty,
  input  logic        chnl_rx_ack,
  input  logic        chnl_rx_data_ren,
  output logic        rx_recvd,
  output logic        rx_ack_recvd,
  output logic        rx_done,
  output logic        rx_timeout,
  output logic [31:0] rx_consumed,
  output logic        rd_en,
  output logic        chnl_rx,
  output logic        chnl_rx_last,
  output logic [31:0] chnl_rx_len,
  output logic [30:0] chnl_rx_off,
  output logic        chnl_rx_data_valid
);

  localparam int W   = words_per_beat(C_DATA_WIDTH);
  localparam int TCW = tcnt_width(C_ACK_TIMEOUT);

  gate_state_e    state, state_nxt;
  logic [TCW-1:0] tcnt;
  logic [31:0]    remain, step, consumed_nxt;
  logic           expired, timeout_nxt, done_q, timeout_q;

  always_comb begin
    remain       = chnl_rx_len - rx_consumed;
    step         = (remain < 32'(W)) ? remain : 32'(W);
    consumed_nxt = rx_consumed + step;
    expired      = (C_ACK_TIMEOUT != 0) && (tcnt == TCW'(C_ACK_TIMEOUT - 1));
    // rx gates the data path too, so an aborting transfer never pulls another beat
    chnl_rx_data_valid = (state == ST_XFER) && rx && !rd_empty && (rx_consumed < chnl_rx_len);
    rd_en              = chnl_rx_data_valid && chnl_rx_data_ren;
    rx_ack_recvd       = (state == ST_OFFER) && rx && chnl_rx_ack;
    chnl_rx            = (state == ST_OFFER) || (state == ST_XFER);
    rx_recvd           = chnl_rx;
    state_nxt   = state;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE:  if (rx) state_nxt = ST_OFFER;
      ST_OFFER: begin
        if (!rx)                state_nxt = ST_DONE;
        else if (chnl_rx_ack)   state_nxt = (chnl_rx_len == '0) ? ST_DONE : ST_XFER;
        else if (expired) begin
          state_nxt   = ST_DONE;
          timeout_nxt = 1'b1;
        end
      end
      ST_XFER: begin
        if (!rx)                                      state_nxt = ST_DONE;
        else if (rd_en && consumed_nxt == chnl_rx_len) state_nxt = ST_DONE;
      end
      ST_DONE:  if (!rx) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      tcnt         <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      rx_consumed  <= '0;
      chnl_rx_len  <= '0;
      chnl_rx_off  <= '0;
      chnl_rx_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_q    <= (state != ST_DONE) && (state_nxt == ST_DONE);
      timeout_q <= timeout_nxt;
      if (state == ST_IDLE && rx) begin
        chnl_rx_len  <= rx_len;
        chnl_rx_off  <= rx_off;
        chnl_rx_last <= rx_last;
        rx_consumed  <= '0;
        tcnt         <= '0;
      end
      if (state == ST_OFFER) tcnt <= tcnt + TCW'(1);
      if (rd_en)             rx_consumed <= consumed_nxt;
    end
  end

  assign rx_done    = done_q;
  assign rx_timeout = timeout_q;

endmodule

// File: rtl/rx_multi_channel_gate.sv
// Multi-channel RX gate: one independent gate FSM per channel over packed per-channel buses.
module rx_multi_channel_gate
  import rx_gate_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_NUM_CHNL    = 4,
  parameter int C_ACK_TIMEOUT = 1024
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [C_NUM_CHNL-1:0]              RX,
  output logic [C_NUM_CHNL-1:0]              RX_RECVD,
  output logic [C_NUM_CHNL-1:0]              RX_ACK_RECVD,
  output logic [C_NUM_CHNL-1:0]              RX_DONE,
  output logic [C_NUM_CHNL-1:0]              RX_TIMEOUT,
  input  logic [C_NUM_CHNL-1:0]              RX_LAST,
  input  logic [32*C_NUM_CHNL-1:0]           RX_LEN,
  input  logic [31*C_NUM_CHNL-1:0]           RX_OFF,
  output logic [32*C_NUM_CHNL-1:0]           RX_CONSUMED,
  input  logic [C_DATA_WIDTH*C_NUM_CHNL-1:0] RD_DATA,
  input  logic [C_NUM_CHNL-1:0]              RD_EMPTY,
  output logic [C_NUM_CHNL-1:0]              RD_EN,
  output logic [C_NUM_CHNL-1:0]              CHNL_RX,
  input  logic [C_NUM_CHNL-1:0]              CHNL_RX_ACK,
  output logic [C_NUM_CHNL-1:0]              CHNL_RX_LAST,
  output logic [32*C_NUM_CHNL-1:0]           CHNL_RX_LEN,
  output logic [31*C_NUM_CHNL-1:0]           CHNL_RX_OFF,
  output logic [C_DATA_WIDTH*C_NUM_CHNL-1:0] CHNL_RX_DATA,
  output logic [C_NUM_CHNL-1:0]              CHNL_RX_DATA_VALID,
  input  logic [C_NUM_CHNL-1:0]              CHNL_RX_DATA_REN
);

  for (genvar i = 0; i < C_NUM_CHNL; i++) begin : g_chnl
    rx_channel_gate_fsm #(
      .C_DATA_WIDTH (C_DATA_WIDTH),
      .C_ACK_TIMEOUT(C_ACK_TIMEOUT)
    ) u_gate (
      .clk               (CLK),
      .rst               (RST),
      .rx                (RX[i]),
      .rx_last           (RX_LAST[i]),
      .rx_len            (RX_LEN[32*i +: 32]),
      .rx_off            (RX_OFF[31*i +: 31]),
      .rd_empty          (RD_EMPTY[i]),
      .chnl_rx_ack       (CHNL_RX_ACK[i]),
      .chnl_rx_data_ren  (CHNL_RX_DATA_REN[i]),
      .rx_recvd          (RX_RECVD[i]),
      .rx_ack_recvd      (RX_ACK_RECVD[i]),
      .rx_done           (RX_DONE[i]),
      .rx_timeout        (RX_TIMEOUT[i]),
      .rx_consumed       (RX_CONSUMED[32*i +: 32]),
      .rd_en             (RD_EN[i]),
      .chnl_rx           (CHNL_RX[i]),
      .chnl_rx_last      (CHNL_RX_LAST[i]),
      .chnl_rx_len       (CHNL_RX_LEN[32*i +: 32]),
      .chnl_rx_off       (CHNL_RX_OFF[31*i +: 31]),
      .chnl_rx_data_valid(CHNL_RX_DATA_VALID[i])
    );
    // data is a straight pass-through; the gate only qualifies it
    assign CHNL_RX_DATA[C_DATA_WIDTH*i +: C_DATA_WIDTH] = RD_DATA[C_DATA_WIDTH*i +: C_DATA_WIDTH];
  end

endmodule

// File: tb/tb_rx_multi_channel_gate.sv
// Bench for rx_multi_channel_gate: table-driven transactions with a done-time scoreboard plus corner sequences.
module tb_rx_multi_channel_gate;
  localparam int N = 4, DW = 64, TO = 16;
  localparam int BDW = 128;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic [N-1:0]      rx, rx_recvd, rx_ack_recvd, rx_done, rx_timeout, rx_last;
  logic [32*N-1:0]   rx_len, rx_consumed, chnl_rx_len;
  logic [31*N-1:0]   rx_off, chnl_rx_off;
  logic [DW*N-1:0]   rd_data, chnl_rx_data;
  logic [N-1:0]      rd_empty, rd_en, chnl_rx, chnl_rx_ack, chnl_rx_last, chnl_rx_data_valid, chnl_rx_data_ren;

  logic        b_rx, b_rx_recvd, b_rx_ack_recvd, b_rx_done, b_rx_timeout, b_rx_last;
  logic [31:0] b_rx_len, b_rx_consumed, b_chnl_rx_len;
  logic [30:0] b_rx_off, b_chnl_rx_off;
  logic [BDW-1:0] b_rd_data, b_chnl_rx_data;
  logic        b_rd_empty, b_rd_en, b_chnl_rx, b_chnl_rx_ack, b_chnl_rx_last, b_valid, b_ren;

  rx_multi_channel_gate #(.C_DATA_WIDTH(DW), .C_NUM_CHNL(N), .C_ACK_TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .RX(rx), .RX_RECVD(rx_recvd), .RX_ACK_RECVD(rx_ack_recvd),
    .RX_DONE(rx_done), .RX_TIMEOUT(rx_timeout), .RX_LAST(rx_last), .RX_LEN(rx_len),
    .RX_OFF(rx_off), .RX_CONSUMED(rx_consumed), .RD_DATA(rd_data), .RD_EMPTY(rd_empty),
    .RD_EN(rd_en), .CHNL_RX(chnl_rx), .CHNL_RX_ACK(chnl_rx_ack), .CHNL_RX_LAST(chnl_rx_last),
    .CHNL_RX_LEN(chnl_rx_len), .CHNL_RX_OFF(chnl_rx_off), .CHNL_RX_DATA(chnl_rx_data),
    .CHNL_RX_DATA_VALID(chnl_rx_data_valid), .CHNL_RX_DATA_REN(chnl_rx_data_ren));

  rx_multi_channel_gate #(.C_DATA_WIDTH(BDW), .C_NUM_CHNL(1), .C_ACK_TIMEOUT(TO)) dut128 (
    .CLK(clk), .RST(rst), .RX(b_rx), .RX_RECVD(b_rx_recvd), .RX_ACK_RECVD(b_rx_ack_recvd),
    .RX_DONE(b_rx_done), .RX_TIMEOUT(b_rx_timeout), .RX_LAST(b_rx_last), .RX_LEN(b_rx_len),
    .RX_OFF(b_rx_off), .RX_CONSUMED(b_rx_consumed), .RD_DATA(b_rd_data), .RD_EMPTY(b_rd_empty),
    .RD_EN(b_rd_en), .CHNL_RX(b_chnl_rx), .CHNL_RX_ACK(b_chnl_rx_ack), .CHNL_RX_LAST(b_chnl_rx_last),
    .CHNL_RX_LEN(b_chnl_rx_len), .CHNL_RX_OFF(b_chnl_rx_off), .CHNL_RX_DATA(b_chnl_rx_data),
    .CHNL_RX_DATA_VALID(b_valid), .CHNL_RX_DATA_REN(b_ren));

  typedef struct { int ch; int cons; int beats; bit to; int rden_base; } exp_t;
  typedef struct { int ch; int len; int ack_dly; int cons; int beats; bit to; } vec_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int rden_cnt[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // fresh FIFO data every cycle so the pass-through check sees changing values
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < DW*N/32; k++) rd_data[32*k +: 32] = $urandom;
    for (int k = 0; k < BDW/32; k++)  b_rd_data[32*k +: 32] = $urandom;
  end

  // scoreboard: each RX_DONE pops the matching channel's expectation
  always @(negedge clk) begin
    int   idx;
    exp_t e;
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        if (rd_en[c]) begin
          rden_cnt[c]++;
          check("rden_while_empty", rd_empty[c], 1'b0);
        end
        if (chnl_rx_data_valid[c]) check("data_pass", chnl_rx_data[DW*c +: DW], rd_data[DW*c +: DW]);
        if (rx_timeout[c]) check("timeout_with_done", rx_done[c], 1'b1);
        if (rx_done[c]) begin
          idx = -1;
          foreach (sb[k]) if (idx < 0 && sb[k].ch == c) idx = k;
          if (idx < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: ch%0d got done want none", c);
          end else begin
            e = sb[idx];
            sb.delete(idx);
            check("consumed", rx_consumed[32*c +: 32], 64'(e.cons));
            check("timeout_flag", rx_timeout[c], e.to);
            check("rd_en_beats", 64'(rden_cnt[c] - e.rden_base), 64'(e.beats));
          end
        end
      end
    end
  end

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   n;
    bit   seen;
    @(posedge clk); #1;
    rx_len[32*v.ch +: 32]  = 32'(v.len);
    rx_off[31*v.ch +: 31]  = 31'(v.len*3 + v.ch + 1);
    rx_last[v.ch]          = (v.ch % 2 == 1);
    rd_empty[v.ch]         = 1'b0;
    chnl_rx_data_ren[v.ch] = 1'b1;
    chnl_rx_ack[v.ch]      = 1'b0;
    e.ch = v.ch; e.cons = v.cons; e.beats = v.beats; e.to = v.to; e.rden_base = rden_cnt[v.ch];
    sb.push_back(e);
    rx[v.ch] = 1'b1;
    #1 check("chnl_rx_idle", chnl_rx[v.ch], 1'b0);
    @(posedge clk); #1;
    check("chnl_rx_offer", chnl_rx[v.ch], 1'b1);
    check("len_latch", chnl_rx_len[32*v.ch +: 32], 64'(v.len));
    check("off_latch", chnl_rx_off[31*v.ch +: 31], 64'(v.len*3 + v.ch + 1));
    check("last_latch", chnl_rx_last[v.ch], (v.ch % 2 == 1));
    rx_len[32*v.ch +: 32] = 32'hdead;
    if (v.ack_dly >= 0) begin
      repeat (v.ack_dly) begin @(posedge clk); #1; end
      chnl_rx_ack[v.ch] = 1'b1;
      #1 check("ack_pulse", rx_ack_recvd[v.ch], 1'b1);
      @(posedge clk); #1;
      chnl_rx_ack[v.ch] = 1'b0;
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = rx_done[v.ch];
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: ch%0d no RX_DONE within %0d cycles", v.ch, n);
    end
    if (v.to) check("timeout_latency", 64'(n), 64'(TO + 1));
    check("chnl_rx_dropped", chnl_rx[v.ch], 1'b0);
    check("len_hold", chnl_rx_len[32*v.ch +: 32], 64'(v.len));
    repeat (2) @(posedge clk);
    #1;
    rx[v.ch] = 1'b0; chnl_rx_data_ren[v.ch] = 1'b0; rd_empty[v.ch] = 1'b1;
    @(posedge clk); #1;
    check("consumed_hold", rx_consumed[32*v.ch +: 32], 64'(v.cons));
  endtask

  task automatic check_all_zero();
    check("rst_ctrl", {chnl_rx, rx_recvd, rx_ack_recvd, rx_done, rx_timeout, rd_en, chnl_rx_data_valid, chnl_rx_last}, '0);
    check("rst_len", |chnl_rx_len, 1'b0);
    check("rst_off", |chnl_rx_off, 1'b0);
    check("rst_consumed", |rx_consumed, 1'b0);
  endtask

  vec_t vecs[6];
  exp_t ea;
  int   n;
  bit   seen;

  initial begin
    rst = 1'b1;
    rx = '0; rx_last = '0; rx_len = '0; rx_off = '0; rd_empty = '1;
    chnl_rx_ack = '0; chnl_rx_data_ren = '0; rd_data = '0;
    b_rx = 1'b0; b_rx_last = 1'b0; b_rx_len = '0; b_rx_off = '0; b_rd_empty = 1'b1;
    b_chnl_rx_ack = 1'b0; b_ren = 1'b0; b_rd_data = '0;
    for (int c = 0; c < N; c++) rden_cnt[c] = 0;
    vecs[0] = '{0, 8, 3, 8, 4, 1'b0};
    vecs[1] = '{1, 5, 0, 5, 3, 1'b0};
    vecs[2] = '{2, 1, 1, 1, 1, 1'b0};
    vecs[3] = '{3, 0, 2, 0, 0, 1'b0};   // zero length: ack goes straight to done
    vecs[4] = '{0, 4, -1, 0, 0, 1'b1};  // no ack: timeout
    vecs[5] = '{3, 3, 15, 3, 2, 1'b0};  // ack on the expiry cycle wins
    repeat (3) @(posedge clk);
    #1 check_all_zero();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // abort: LEN=16, drop RX after 3 beats with REN still high
    @(posedge clk); #1;
    rx_len[31:0] = 32'd16; rd_empty[0] = 1'b0; chnl_rx_data_ren[0] = 1'b1; chnl_rx_ack[0] = 1'b1;
    ea.ch = 0; ea.cons = 6; ea.beats = 3; ea.to = 1'b0; ea.rden_base = rden_cnt[0];
    sb.push_back(ea);
    rx[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_ack_pulse", rx_ack_recvd[0], 1'b1);
    @(posedge clk); #1;
    chnl_rx_ack[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx[0] = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin @(negedge clk); n++; seen = rx_done[0]; end
    if (!seen) begin n_cmp++; n_bad++; $display("FAIL abort_done: no RX_DONE within %0d cycles", n); end
    check("abort_chnl_rx", chnl_rx[0], 1'b0);
    @(posedge clk); #1;
    check("abort_consumed_hold", rx_consumed[31:0], 64'd6);
    rd_empty[0] = 1'b1; chnl_rx_data_ren[0] = 1'b0;

    // 128-bit datapath, LEN=7: consumed 4 then 7, valid drops with FIFO still non-empty
    @(posedge clk); #1;
    b_rx_len = 32'd7; b_rd_empty = 1'b0; b_ren = 1'b1; b_chnl_rx_ack = 1'b1; b_rx = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_chnl_rx_ack = 1'b0;
    check("w4_valid_beat1", b_valid, 1'b1);
    check("w4_rden_beat1", b_rd_en, 1'b1);
    check("w4_data_pass", b_chnl_rx_data, b_rd_data);
    @(posedge clk); #1;
    check("w4_consumed_4", b_rx_consumed, 64'd4);
    check("w4_valid_beat2", b_valid, 1'b1);
    @(posedge clk); #1;
    check("w4_consumed_7", b_rx_consumed, 64'd7);
    check("w4_valid_low", b_valid, 1'b0);
    check("w4_done", b_rx_done, 1'b1);
    b_rx = 1'b0; b_ren = 1'b0; b_rd_empty = 1'b1;

    // ch1 completes while ch2 is stalled on an empty FIFO, then reset mid-transfer
    @(posedge clk); #1;
    rx_len[63:32] = 32'd4; rx_len[95:64] = 32'd4;
    rd_empty[1] = 1'b0; rd_empty[2] = 1'b1;
    chnl_rx_data_ren[2:1] = 2'b11; chnl_rx_ack[2:1] = 2'b11;
    ea.ch = 1; ea.cons = 4; ea.beats = 2; ea.to = 1'b0; ea.rden_base = rden_cnt[1];
    sb.push_back(ea);
    rx[2:1] = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chnl_rx_ack[2:1] = 2'b00;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin @(negedge clk); n++; seen = rx_done[1]; end
    if (!seen) begin n_cmp++; n_bad++; $display("FAIL conc_done: ch1 no RX_DONE within %0d cycles", n); end
    check("conc_ch2_active", chnl_rx[2], 1'b1);
    check("conc_ch2_valid", chnl_rx_data_valid[2], 1'b0);
    check("conc_ch2_consumed", rx_consumed[95:64], 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; rx = '0; chnl_rx_data_ren = '0; rd_empty = '1;
    @(posedge clk); #1;
    check_all_zero();
    rst = 1'b0;
    run_txn('{2, 4, 0, 4, 2, 1'b0});

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
